// File: rtl/collision_check_scheduler.sv
// collision_check_scheduler: round-robin time-sharing of one piece_mask_generator
// between N_REQ game-logic requesters. A granted request drives the generator's
// piece_x/piece_y, captures the returned 6x6 window, scans the 4x4 shape against
// it one column per cycle and answers with a one-cycle done pulse plus collide.

// Per-column overlap test: any shape cell in this column landing on a set window cell.
module ccs_col_hit (
  input  logic [3:0] shape_col,
  input  logic [3:0] win_col,
  output logic       hit
);
  assign hit = |(shape_col & win_col);
endmodule

module collision_check_scheduler #(
  parameter  int BOARD_WIDTH  = 10,
  parameter  int BOARD_HEIGHT = 20,
  parameter  int N_REQ        = 3,
  localparam int XW = $clog2(BOARD_WIDTH),
  localparam int YW = $clog2(BOARD_HEIGHT),
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0][XW-1:0]   req_x,
  input  logic [N_REQ-1:0][YW-1:0]   req_y,
  input  logic [N_REQ-1:0][15:0]     req_shape,
  output logic [N_REQ-1:0]           done,
  output logic                       collide,
  output logic                       busy,
  output logic [IW-1:0]              gnt_idx,
  output logic [XW-1:0]              mask_x,
  output logic [YW-1:0]              mask_y,
  input  logic [5:0][5:0]            window
);

  typedef enum logic [1:0] {IDLE, FETCH, SCAN, RESP} state_t;

  state_t         state;
  logic [IW-1:0]  ptr;
  logic [15:0]    shape_q;
  logic [5:0][5:0] win_q;
  logic           hit;
  logic [1:0]     col;

  logic           found;
  logic [IW-1:0]  pick;
  logic [IW:0]    cand;
  logic [3:0]     col_hit;

  // Round-robin pick: first set req at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr} + (IW+1)'(i);
      if (cand >= (IW+1)'(N_REQ)) cand = cand - (IW+1)'(N_REQ);
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IW-1:0];
      end
    end
  end

  // Shape is anchored at window local (1,1), so shape column c meets window
  // column c+1 and rows 1..4; the outer ring of the window is never consulted.
  for (genvar c = 0; c < 4; c++) begin : g_col
    ccs_col_hit u_col (
      .shape_col (shape_q[c*4 +: 4]),
      .win_col   (win_q[c+1][4:1]),
      .hit       (col_hit[c])
    );
  end

  logic unused_win;
  assign unused_win = ^{win_q[0], win_q[5],
                        win_q[1][0], win_q[1][5], win_q[2][0], win_q[2][5],
                        win_q[3][0], win_q[3][5], win_q[4][0], win_q[4][5]};

  // Busy covers the grant cycle itself, hence the combinational term in IDLE.
  assign busy = (state != IDLE) || (reset_n && found);

  // Control FSM: grant, fetch window, 4-column scan, respond.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      done    <= '0;
      collide <= 1'b0;
      gnt_idx <= '0;
      mask_x  <= '0;
      mask_y  <= '0;
      ptr     <= '0;
      hit     <= 1'b0;
      col     <= '0;
      shape_q <= '0;
      win_q   <= '0;
    end else begin
      done    <= '0;
      collide <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt_idx <= pick;
            mask_x  <= req_x[pick];
            mask_y  <= req_y[pick];
            shape_q <= req_shape[pick];
            hit     <= 1'b0;
            col     <= '0;
            state   <= FETCH;
          end
        end
        FETCH: begin
          // Generator is combinational off mask_x/mask_y, so window is valid now.
          win_q <= window;
          col   <= '0;
          state <= SCAN;
        end
        SCAN: begin
          // Fixed-length scan: no early exit, latency independent of result.
          hit <= hit | col_hit[col];
          col <= col + 2'd1;
          if (col == 2'd3) begin
            done    <= N_REQ'(1) << gnt_idx;
            collide <= hit | col_hit[col];
            state   <= RESP;
          end
        end
        RESP: begin
          ptr   <= (gnt_idx == IW'(N_REQ-1)) ? '0 : gnt_idx + IW'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
